// File: rtl/pipe_tb_pkg.sv
// Shared types and default constants for the pipeline end-of-test monitor.
package pipe_tb_pkg;

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, PASS, FAIL} mon_state_t;

  localparam logic [1:0] FC_NONE       = 2'd0;
  localparam logic [1:0] FC_TIMEOUT    = 2'd1;
  localparam logic [1:0] FC_FAIL_STORE = 2'd2;
  localparam logic [1:0] FC_BAD_DATA   = 2'd3;

  localparam int unsigned DEF_END_PC    = 292;
  localparam int unsigned DEF_PASS_ADDR = 100;
  localparam int unsigned DEF_PASS_DATA = 25;
  localparam int unsigned DEF_FAIL_ADDR = 96;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clr has priority over en.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (en && (q_q != '1)) begin
      q_d = q_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/pipe_test_monitor.sv
// End-of-test monitor: verdict from end-PC, signature store or cycle timeout.
// Optional store signature output enabled by PIPE_TEST_MONITOR_SIG_EN.
module pipe_test_monitor
  import pipe_tb_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned END_PC       = DEF_END_PC,
  parameter int unsigned END_PC_CHK   = 1,
  parameter int unsigned PASS_ADDR    = DEF_PASS_ADDR,
  parameter int unsigned PASS_DATA    = DEF_PASS_DATA,
  parameter int unsigned FAIL_ADDR    = DEF_FAIL_ADDR,
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter int unsigned TIMEOUT      = 100000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  pc_d,
  input  logic             mem_write_m,
  input  logic [XLEN-1:0]  alu_result_m,
  input  logic [XLEN-1:0]  write_data_m,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [1:0]       fail_code,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] store_count,
`ifdef PIPE_TEST_MONITOR_SIG_EN
  output logic [XLEN-1:0]  signature,
`endif
  output mon_state_t       dbg_state
);

  mon_state_t       state_q, state_d;
  logic [1:0]       fc_q, fc_d;
  logic [CNT_W-1:0] drain_cnt;
  logic             active, in_drain, store;
  logic             fail_hit, pass_hit, pass_ok, end_hit, to_hit, drain_done;

  assign active   = (state_q == RUN) || (state_q == DRAIN);
  assign in_drain = (state_q == DRAIN);
  // An unknown strobe compares unequal to 1 and is therefore not a store.
  assign store    = (mem_write_m === 1'b1);

  // Equal fail/pass addresses switch the dedicated fail address off.
  assign fail_hit   = store && (FAIL_ADDR != PASS_ADDR) && (alu_result_m == XLEN'(FAIL_ADDR));
  assign pass_hit   = store && (alu_result_m == XLEN'(PASS_ADDR));
  assign pass_ok    = (write_data_m == XLEN'(PASS_DATA));
  assign end_hit    = (END_PC_CHK != 0) && (pc_d == XLEN'(END_PC));
  assign to_hit     = (TIMEOUT != 0) && (cycle_count == CNT_W'(TIMEOUT - 1));
  assign drain_done = (DRAIN_CYCLES == 0) || (drain_cnt == CNT_W'(DRAIN_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    fc_d    = fc_q;
    case (state_q)
      IDLE: state_d = RUN;
      RUN: begin
        if (fail_hit) begin
          state_d = FAIL;
          fc_d    = FC_FAIL_STORE;
        end else if (pass_hit) begin
          if (pass_ok) begin
            state_d = DRAIN;
          end else begin
            state_d = FAIL;
            fc_d    = FC_BAD_DATA;
          end
        end else if (end_hit) begin
          state_d = DRAIN;
        end else if (to_hit) begin
          state_d = FAIL;
          fc_d    = FC_TIMEOUT;
        end
      end
      DRAIN: begin
        if (fail_hit) begin
          state_d = FAIL;
          fc_d    = FC_FAIL_STORE;
        end else if (pass_hit && !pass_ok) begin
          state_d = FAIL;
          fc_d    = FC_BAD_DATA;
        end else if (drain_done) begin
          state_d = PASS;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      fc_q    <= FC_NONE;
    end else begin
      state_q <= state_d;
      fc_q    <= fc_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk (clk), .rst (rst), .en (active), .clr (1'b0), .q (cycle_count)
  );

  sat_counter #(.W(CNT_W)) u_store_cnt (
    .clk (clk), .rst (rst), .en (active && store), .clr (1'b0), .q (store_count)
  );

  // Held at zero outside DRAIN so it always starts from 0 on entry.
  sat_counter #(.W(CNT_W)) u_drain_cnt (
    .clk (clk), .rst (rst), .en (in_drain), .clr (!in_drain), .q (drain_cnt)
  );

`ifdef PIPE_TEST_MONITOR_SIG_EN
  logic [XLEN-1:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (active && store) begin
      sig_d = {sig_q[XLEN-2:0], sig_q[XLEN-1]} ^ alu_result_m ^ write_data_m;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sig_q <= '0;
    else     sig_q <= sig_d;
  end

  assign signature = sig_q;
`endif

  assign done      = (state_q == PASS) || (state_q == FAIL);
  assign pass      = (state_q == PASS);
  assign fail      = (state_q == FAIL);
  assign fail_code = fc_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pipe_test_monitor.sv
// Self-checking bench for pipe_test_monitor (TIMEOUT shortened to 50 cycles).
module tb_pipe_test_monitor;
  import pipe_tb_pkg::*;

  localparam int XLEN  = 32;
  localparam int CNT_W = 32;
  localparam int TO    = 50;
  localparam int W     = 5 + 2 * CNT_W;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [XLEN-1:0]  pc_d = '0;
  logic             mem_write_m = 1'b0;
  logic [XLEN-1:0]  alu_result_m = '0;
  logic [XLEN-1:0]  write_data_m = '0;
  logic             done, pass, fail;
  logic [1:0]       fail_code;
  logic [CNT_W-1:0] cycle_count, store_count;
  mon_state_t       dbg_state;
`ifdef PIPE_TEST_MONITOR_SIG_EN
  logic [XLEN-1:0]  signature;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [XLEN-1:0] sig_m;
  logic [W-1:0]    exp_q[$];
  logic [W-1:0]    obs;

  assign obs = {done, pass, fail, fail_code, cycle_count, store_count};

  pipe_test_monitor #(.TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_d         (pc_d),
    .mem_write_m  (mem_write_m),
    .alu_result_m (alu_result_m),
    .write_data_m (write_data_m),
    .done         (done),
    .pass         (pass),
    .fail         (fail),
    .fail_code    (fail_code),
    .cycle_count  (cycle_count),
    .store_count  (store_count),
`ifdef PIPE_TEST_MONITOR_SIG_EN
    .signature    (signature),
`endif
    .dbg_state    (dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  // Model helpers
  function automatic logic [W-1:0] mk(input logic p, input logic f, input logic [1:0] fc,
                                      input int cc, input int sc);
    return {1'b1, p, f, fc, CNT_W'(cc), CNT_W'(sc)};
  endfunction

  function automatic logic [XLEN-1:0] rotl1(input logic [XLEN-1:0] v);
    return {v[XLEN-2:0], v[XLEN-1]};
  endfunction

  // Driver tasks: inputs change on the falling edge, one call = one cycle
  task automatic drive(input logic [XLEN-1:0] pc, input logic we,
                       input logic [XLEN-1:0] a, input logic [XLEN-1:0] d);
    pc_d = pc; mem_write_m = we; alu_result_m = a; write_data_m = d;
    @(posedge clk);
    @(negedge clk);
    pc_d = '0; mem_write_m = 1'b0; alu_result_m = '0; write_data_m = '0;
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) drive('0, 1'b0, '0, '0);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cyc = 0;
    sig_m = '0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      idle(1);
      n++;
    end
  endtask

  // Scenarios
  task automatic test_reset;
    #3 rst = 1'b1;
    #1;
    checks++;
    if (obs !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", obs);
    end
    checks++;
    if (dbg_state !== IDLE) begin
      errors++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE);
    end
`ifdef PIPE_TEST_MONITOR_SIG_EN
    checks++;
    if (signature !== '0) begin
      errors++; $display("FAIL reset_signature: got %h expected 0", signature);
    end
`endif
    do_reset();
    checks++;
    if (dbg_state !== RUN || cycle_count !== '0) begin
      errors++; $display("FAIL reset_to_run: state %0d cycles %0d, expected RUN and 0", dbg_state, cycle_count);
    end
  endtask

  task automatic test_end_pc;
    logic [W-1:0] exp;
    do_reset();
    exp_q.push_back(mk(1'b1, 1'b0, FC_NONE, 43, 0));
    idle(40);
    drive(XLEN'(292), 1'b0, '0, '0);
    idle(1);
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL end_pc_early: done %b at cycle %0d, expected 0", done, cycle_count);
    end
    idle(1);
    exp = exp_q.pop_front();
    checks++;
    if (obs !== exp) begin
      errors++; $display("FAIL end_pc_verdict: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_signature;
    logic [W-1:0] exp;
    do_reset();
    exp_q.push_back(mk(1'b1, 1'b0, FC_NONE, 11, 2));
    idle(5);
    drive('0, 1'b1, XLEN'(84), XLEN'(7));
    sig_m = rotl1(sig_m) ^ XLEN'(84) ^ XLEN'(7);
    idle(2);
    drive('0, 1'b1, XLEN'(100), XLEN'(25));
    sig_m = rotl1(sig_m) ^ XLEN'(100) ^ XLEN'(25);
    wait_done(10);
    exp = exp_q.pop_front();
    checks++;
    if (obs !== exp) begin
      errors++; $display("FAIL signature_verdict: got %h expected %h", obs, exp);
    end
`ifdef PIPE_TEST_MONITOR_SIG_EN
    checks++;
    if (signature !== sig_m) begin
      errors++; $display("FAIL signature_value: got %h expected %h", signature, sig_m);
    end
`endif
  endtask

  task automatic test_bad_data;
    logic [W-1:0] exp;
    do_reset();
    exp_q.push_back(mk(1'b0, 1'b1, FC_BAD_DATA, 4, 1));
    idle(3);
    drive('0, 1'b1, XLEN'(100), XLEN'(24));
    exp = exp_q.pop_front();
    checks++;
    if (obs !== exp) begin
      errors++; $display("FAIL bad_data_verdict: got %h expected %h", obs, exp);
    end
    drive(XLEN'(292), 1'b0, '0, '0);
    drive(XLEN'(292), 1'b1, XLEN'(100), XLEN'(25));
    idle(2);
    checks++;
    if (obs !== exp) begin
      errors++; $display("FAIL bad_data_sticky: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_timeout;
    logic [W-1:0] exp;
    do_reset();
    exp_q.push_back(mk(1'b0, 1'b1, FC_TIMEOUT, TO, 0));
    wait_done(TO + 10);
    exp = exp_q.pop_front();
    checks++;
    if (obs !== exp) begin
      errors++; $display("FAIL timeout_verdict: got %h expected %h", obs, exp);
    end
    checks++;
    if (cyc !== TO) begin
      errors++; $display("FAIL timeout_latency: got %0d cycles expected %0d", cyc, TO);
    end
  endtask

  task automatic test_fail_store;
    logic [W-1:0] exp;
    do_reset();
    exp_q.push_back(mk(1'b0, 1'b1, FC_FAIL_STORE, 11, 1));
    idle(10);
    drive('0, 1'b1, XLEN'(96), XLEN'(0));
    wait_done(2);
    exp = exp_q.pop_front();
    checks++;
    if (obs !== exp) begin
      errors++; $display("FAIL fail_store_verdict: got %h expected %h", obs, exp);
    end
    // Fail store landing on the timeout cycle reports the store code.
    do_reset();
    exp_q.push_back(mk(1'b0, 1'b1, FC_FAIL_STORE, TO, 1));
    idle(TO - 1);
    drive('0, 1'b1, XLEN'(96), XLEN'(5));
    wait_done(2);
    exp = exp_q.pop_front();
    checks++;
    if (obs !== exp) begin
      errors++; $display("FAIL fail_on_timeout_verdict: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_reset_mid_drain;
    do_reset();
    idle(2);
    drive('0, 1'b1, XLEN'(84), XLEN'(1));
    drive(XLEN'(292), 1'b0, '0, '0);
    checks++;
    if (dbg_state !== DRAIN) begin
      errors++; $display("FAIL mid_drain_entry: state %0d expected %0d", dbg_state, DRAIN);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (obs !== '0 || dbg_state !== IDLE) begin
      errors++; $display("FAIL mid_drain_clear: got %h state %0d expected 0 and IDLE", obs, dbg_state);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (dbg_state !== RUN || cycle_count !== '0) begin
      errors++; $display("FAIL mid_drain_restart: state %0d cycles %0d expected RUN and 0", dbg_state, cycle_count);
    end
    idle(3);
    checks++;
    if (cycle_count !== CNT_W'(3) || store_count !== '0) begin
      errors++; $display("FAIL mid_drain_recount: cycles %0d stores %0d expected 3 and 0", cycle_count, store_count);
    end
  endtask

  task automatic test_simultaneous;
    logic [W-1:0] exp;
    do_reset();
    exp_q.push_back(mk(1'b1, 1'b0, FC_NONE, 7, 1));
    idle(4);
    drive(XLEN'(292), 1'b1, XLEN'(100), XLEN'(25));
    wait_done(5);
    exp = exp_q.pop_front();
    checks++;
    if (obs !== exp) begin
      errors++; $display("FAIL simultaneous_verdict: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_drain_fail;
    logic [W-1:0] exp;
    do_reset();
    exp_q.push_back(mk(1'b0, 1'b1, FC_FAIL_STORE, 6, 1));
    idle(4);
    drive(XLEN'(292), 1'b0, '0, '0);
    drive('0, 1'b1, XLEN'(96), XLEN'(0));
    wait_done(2);
    exp = exp_q.pop_front();
    checks++;
    if (obs !== exp) begin
      errors++; $display("FAIL drain_fail_verdict: got %h expected %h", obs, exp);
    end
  endtask

  initial begin
    test_reset();
    test_end_pc();
    test_signature();
    test_bad_data();
    test_timeout();
    test_fail_store();
    test_reset_mid_drain();
    test_simultaneous();
    test_drain_fail();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
